// File: rtl/regfile_dumper_pkg.sv
// Shared CPU definitions for the register-file dumper: index/data widths,
// FSM state encoding and the buffered word layout.
package regfile_dumper_pkg;

  localparam int IDX_W   = 5;
  localparam int DATA_W  = 32;
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = DATA_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } entry_t;

endpackage

// File: rtl/dump_fifo.sv
// Output buffer: synchronous FIFO with two push ports (lane 0 written first)
// and one pop port; head word is presented combinationally.
module dump_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push0,
  input  logic [W-1:0]  din0,
  input  logic          push1,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [CW-1:0] free
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr1_ptr;

  assign empty   = (count == '0);
  assign free    = CW'(DEPTH) - count;
  // Second lane lands after the first when both push in one cycle.
  assign wr1_ptr = push0 ? wr_ptr + AW'(1) : wr_ptr;
  // Gated so the outputs read as zero whenever nothing is buffered.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]  <= din0;
    if (push1) mem[wr1_ptr] <= din1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

endmodule

// File: rtl/regfile_dumper.sv
// Streams register-file contents first_reg..last_reg out through a
// valid/ready port, fetching up to two registers per cycle.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] rv1,
  input  logic [31:0] rv2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic [PTR_W-1:0]   ptr, ptr_n1, ptr_n2, last_ext;
  logic [IDX_W-1:0]   last_q;
  logic               fetch, push0, push1, pop, empty;
  logic [CW-1:0]      count, free;
  logic [ENTRY_W-1:0] din0, din1, dout;
  entry_t             head;

  // ptr is one bit wider than an index so last_reg=31 terminates cleanly.
  assign last_ext = {1'b0, last_q};
  assign ptr_n1   = ptr + PTR_W'(1);
  assign ptr_n2   = ptr + PTR_W'(2);

  assign fetch = (state == S_READ) && (free >= CW'(2));
  assign push0 = fetch;
  assign push1 = fetch && (ptr_n1 <= last_ext);
  assign din0  = {rv1, ptr[IDX_W-1:0]};
  assign din1  = {rv2, ptr_n1[IDX_W-1:0]};

  assign rs1 = fetch ? ptr[IDX_W-1:0]    : '0;
  assign rs2 = fetch ? ptr_n1[IDX_W-1:0] : '0;

  assign head      = entry_t'(dout);
  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_idx   = head.idx;
  assign pop       = out_valid && out_ready;

  dump_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (din1),
    .pop   (pop),
    .dout  (dout),
    .count (count),
    .empty (empty),
    .free  (free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      last_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr    <= {1'b0, first_reg};
            last_q <= last_reg;
            busy   <= 1'b1;
            if (first_reg <= last_reg) begin
              state <= S_READ;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (fetch) begin
            ptr <= ptr_n2;
            if (ptr_n2 > last_ext) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: expected words are queued at start
// and popped on every observed output transfer.
module tb_regfile_dumper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0, last_reg = '0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  rs1, rs2, out_idx;
  logic [31:0] rv1, rv2, out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  int done_cnt = 0;
  logic [36:0] sb [$];
  logic        hold_vld = 1'b0;
  logic [36:0] hold_word = '0;

  always #5 clk = ~clk;

  // Register file model: x[i] = 0x1000 + i
  assign rv1 = 32'h1000 + {27'b0, rs1};
  assign rv2 = 32'h1000 + {27'b0, rs2};

  regfile_dumper #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .busy      (busy),
    .done      (done),
    .rs1       (rs1),
    .rs2       (rs2),
    .rv1       (rv1),
    .rv2       (rv2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_vld) chk("hold_word", {out_data, out_idx}, hold_word);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_word", {27'b0, out_idx}, 32'hFFFF);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          chk("out_idx", out_idx, e[4:0]);
          chk("out_data", out_data, e[36:5]);
        end
        pops++;
      end
      hold_vld  = out_valid && !out_ready;
      hold_word = {out_data, out_idx};
      if (done) done_cnt++;
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic expect_range(input int f, input int l);
    for (int i = f; i <= l; i++) sb.push_back({32'h1000 + i, 5'(i)});
  endtask

  // Start is accepted on the second posedge; inputs are scrambled afterwards.
  task automatic do_start(input int f, input int l);
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'(f); last_reg = 5'(l);
    @(posedge clk); #1;
    start = 1'b0; first_reg = 5'($urandom); last_reg = 5'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1'b1);
  endtask

  task automatic run_dump(input int f, input int l, input bit spur, output int cyc);
    logic got;
    int   d0;
    d0 = done_cnt;
    if (f <= l) expect_range(f, l);
    do_start(f, l);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (f <= l && cyc == 1) chk("lat_idle", out_valid, 1'b0);
      if (f <= l && cyc == 2) chk("lat_valid", out_valid, 1'b1);
      if (spur && cyc == 3) begin start = 1'b1; first_reg = 5'd20; last_reg = 5'd25; end
      if (spur && cyc == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1'b1);
    if (f > l) chk("empty_done_lat", cyc, 1);
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("done_once", done_cnt - d0, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int c1, c2, base;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_idx", out_idx, 5'h0);
    chk("rst_rs", {rs1, rs2}, 10'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_dump(0, 31, 0, c1);   // full dump
    run_dump(5, 9, 0, c1);    // odd range
    run_dump(30, 31, 0, c1);  // top of file, no wrap to 0
    run_dump(12, 3, 0, c1);   // empty range

    // Back-pressure: FIFO fills to 4 and fetching stalls
    expect_range(0, 7);
    out_ready = 1'b0;
    do_start(0, 7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) chk("bp_fetch2", {rs1, rs2}, {5'd2, 5'd3});
      if (i == 8) begin
        chk("bp_stall_rs", {rs1, rs2}, 10'h0);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_data", out_data, 32'h1000);
        chk("bp_busy", busy, 1'b1);
      end
    end
    out_ready = 1'b1;
    wait_done(c1);
    @(negedge clk);
    chk("bp_drained", sb.size(), 0);

    // Start while busy must not perturb sequence or timing
    run_dump(0, 7, 0, c1);
    run_dump(0, 7, 1, c2);
    chk("spur_timing", c2, c1);

    // Reset during word 3 of a full dump
    expect_range(0, 31);
    base = pops;
    do_start(0, 31);
    for (int i = 0; i < 50 && pops < base + 3; i++) @(negedge clk);
    chk("rst_mid_reached", pops - base, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_data", out_data, 32'h0);
    sb.delete();
    base = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_cnt - base, 0);
    chk("rst_idle_busy", busy, 1'b0);
    run_dump(0, 1, 0, c1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
